// File: rtl/param_mem_wait.sv
// Word-addressed synchronous memory with req/ready handshake, programmable wait states
// and out-of-range error reporting. Define MEM_BYTE_WRITE_EN for byte-masked writes.
module param_mem_wait #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/8-1:0]   byte_en,
    output logic [DATA_W-1:0]     data_out,
    output logic                  ready,
    output logic                  busy,
    output logic                  err
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CMP_W     = ADDR_W + 1;
    localparam logic [CMP_W-1:0] DEPTH_C  = CMP_W'(DEPTH);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE} state_t;

    state_t              state, state_n;
    logic [3:0]          wait_cnt, wait_cnt_n;
    logic                accept;
    logic                lat_write;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_data;
    logic                in_range;
    logic                do_access;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef MEM_BYTE_WRITE_EN
    localparam int NB = DATA_W / 8;
    logic [NB-1:0]       lat_be;
`else
    logic                unused_byte_en;
    assign unused_byte_en = ^byte_en;
`endif

    // The extra compare bit lets DEPTH equal 2^ADDR_W without overflowing.
    assign in_range  = {1'b0, lat_addr} < DEPTH_C;
    assign idx       = lat_addr[IDX_W-1:0];
    assign do_access = (state == ST_ACCESS);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    wait_cnt_n = WAIT_INIT;
                    state_n    = (WAIT_INIT != 4'd0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                wait_cnt_n = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) state_n = ST_ACCESS;
            end
            ST_ACCESS: state_n = ST_DONE;
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
`ifdef MEM_BYTE_WRITE_EN
            lat_be    <= '0;
`endif
            data_out  <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            busy     <= (state_n != ST_IDLE);
            ready    <= do_access;
            err      <= do_access && !in_range;
            if (accept) begin
                lat_write <= write;
                lat_addr  <= address;
                lat_data  <= data_in;
`ifdef MEM_BYTE_WRITE_EN
                lat_be    <= byte_en;
`endif
            end
            if (do_access) begin
                if (!in_range)       data_out <= '0;
                else if (!lat_write) data_out <= mem[idx];
            end
        end
    end

    // NOTE: the array is deliberately left out of reset; only control and output registers are reset.
    always_ff @(posedge clk) begin
        if (do_access && lat_write && in_range) begin
`ifdef MEM_BYTE_WRITE_EN
            for (int b = 0; b < NB; b++) begin
                if (lat_be[b]) mem[idx][8*b +: 8] <= lat_data[8*b +: 8];
            end
`else
            mem[idx] <= lat_data;
`endif
        end
    end

endmodule

// File: tb/tb_param_mem_wait.sv
// Self-checking bench for param_mem_wait: directed vector table, handshake corner cases
// and randomized traffic against an associative-array memory model.
module tb_param_mem_wait;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 16;
    localparam int DEPTH       = 1024;
    localparam int WAIT_CYCLES = 2;

`ifdef MEM_BYTE_WRITE_EN
    localparam logic [31:0] BYTE_EXP = 32'hDE22BE44;
    localparam logic [31:0] BE0_EXP  = 32'hDE22BE44;
`else
    localparam logic [31:0] BYTE_EXP = 32'h11223344;
    localparam logic [31:0] BE0_EXP  = 32'h00000000;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              req;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [3:0]        byte_en;
    logic [DATA_W-1:0] data_out;
    logic              ready;
    logic              busy;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;

    param_mem_wait #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .write(write), .address(address),
        .data_in(data_in), .byte_en(byte_en), .data_out(data_out),
        .ready(ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One complete transaction; checks handshake timing, returns captured data/err.
    task automatic run_txn(input logic wr, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] be, output logic [31:0] rd, output logic re);
        int lat;
        lat = 0;
        @(negedge clk);
        req = 1'b1; write = wr; address = a; data_in = d; byte_en = be;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("busy_after_accept", 64'(busy), 64'(1));
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) begin
                lat = k;
                break;
            end
        end
        check("ready_latency", 64'(lat), 64'(WAIT_CYCLES + 1));
        rd = data_out;
        re = err;
        check("busy_with_ready", 64'(busy), 64'(1));
        @(negedge clk);
        check("idle_after_done", 64'({busy, ready, err}), 64'(0));
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = new_w;
`ifdef MEM_BYTE_WRITE_EN
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
`else
        if (be == 4'hF) r = new_w | (old_w & 32'h0);
`endif
        return r;
    endfunction

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        re;
        logic [31:0] model_mem [int];
        logic [31:0] last_rd;
        logic [15:0] pool [9];
        int          cnt;
        int          last;

        vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 16'h0010, 32'h00000000, 4'hF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 16'h0400, 32'h00000000, 4'hF, 32'h00000000, 1'b1};
        vecs[3]  = '{1'b0, 16'h0010, 32'h00000000, 4'hF, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 16'h03FF, 32'h12345678, 4'hF, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b0, 16'h03FF, 32'h00000000, 4'hF, 32'h12345678, 1'b0};
        vecs[6]  = '{1'b1, 16'hFFFF, 32'hA5A5A5A5, 4'hF, 32'h00000000, 1'b1};
        vecs[7]  = '{1'b0, 16'h0010, 32'h00000000, 4'hF, 32'hDEADBEEF, 1'b0};
        vecs[8]  = '{1'b1, 16'h0020, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{1'b1, 16'h0020, 32'h11223344, 4'h5, 32'hDEADBEEF, 1'b0};
        vecs[10] = '{1'b0, 16'h0020, 32'h00000000, 4'hF, BYTE_EXP,     1'b0};
        vecs[11] = '{1'b1, 16'h0020, 32'h00000000, 4'h0, BYTE_EXP,     1'b0};
        vecs[12] = '{1'b0, 16'h0020, 32'h00000000, 4'hF, BE0_EXP,      1'b0};

        // Reset: held low for two cycles, outputs cleared, no spurious ready.
        reset = 1'b0; req = 1'b0; write = 1'b0; address = '0; data_in = '0; byte_en = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({data_out, ready, busy, err}), 64'(0));
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready || busy) cnt++;
        end
        check("no_ready_without_req", 64'(cnt), 64'(0));

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, rd, re);
            check($sformatf("vec%0d_data_out", i), 64'(rd), 64'(vecs[i].exp_dout));
            check($sformatf("vec%0d_err", i), 64'(re), 64'(vecs[i].exp_err));
        end

        // req held high: a new acceptance every WAIT_CYCLES+3 cycles.
        @(negedge clk);
        req = 1'b1; write = 1'b0; address = 16'h0010; byte_en = 4'hF;
        cnt = 0; last = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) begin
                cnt++;
                check("b2b_data", 64'(data_out), 64'(32'hDEADBEEF));
                if (last >= 0) check("b2b_period", 64'(c - last), 64'(WAIT_CYCLES + 3));
                else           check("b2b_first", 64'(c), 64'(WAIT_CYCLES + 2));
                last = c;
            end
        end
        req = 1'b0;
        check("b2b_count", 64'(cnt), 64'((30 - (WAIT_CYCLES + 2)) / (WAIT_CYCLES + 3) + 1));
        cnt = 0;
        while (busy && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_drain", 64'(busy), 64'(0));

        // A write request pulsed while busy must be dropped, not queued.
        @(negedge clk);
        req = 1'b1; write = 1'b0; address = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        write = 1'b1; data_in = 32'h00000000;
        repeat (2) @(negedge clk);
        req = 1'b0; write = 1'b0;
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) cnt++;
        end
        check("ignored_req_ready_count", 64'(cnt), 64'(1));
        run_txn(1'b0, 16'h0010, 32'h0, 4'hF, rd, re);
        check("ignored_req_no_write", 64'(rd), 64'(32'hDEADBEEF));

        // Reset during WAIT of a write aborts it with no partial update.
        @(negedge clk);
        req = 1'b1; write = 1'b1; address = 16'h0010; data_in = 32'hCAFEF00D; byte_en = 4'hF;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 check("reset_mid_outputs", 64'({data_out, ready, busy, err}), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_txn(1'b0, 16'h0010, 32'h0, 4'hF, rd, re);
        check("reset_mid_no_write", 64'(rd), 64'(32'hDEADBEEF));
        last_rd = rd;

        // Randomized traffic against the model.
        for (int i = 0; i < 8; i++) pool[i] = 16'h0100 + 16'(i);
        pool[8] = 16'h03FF;
        for (int i = 0; i < 9; i++) begin
            model_mem[int'(pool[i])] = $urandom;
            run_txn(1'b1, pool[i], model_mem[int'(pool[i])], 4'hF, rd, re);
            check("rand_init_data_out", 64'(rd), 64'(last_rd));
        end
        for (int i = 0; i < 40; i++) begin
            logic        wr;
            logic [15:0] a;
            logic [31:0] d;
            logic [3:0]  be;
            logic [31:0] exp_d;
            logic        exp_e;
            int          sel;
            wr  = 1'($urandom_range(1, 0));
            d   = $urandom;
            be  = 4'($urandom_range(15, 0));
            sel = int'($urandom_range(99, 0));
            if (sel < 75)      a = pool[$urandom_range(8, 0)];
            else if (sel < 85) a = 16'(DEPTH);
            else               a = 16'($urandom_range(65535, DEPTH));
            if (int'(a) >= DEPTH) begin
                exp_e = 1'b1;
                exp_d = 32'h0;
            end else if (wr) begin
                exp_e = 1'b0;
                exp_d = last_rd;
                model_mem[int'(a)] = merge(model_mem[int'(a)], d, be);
            end else begin
                exp_e = 1'b0;
                exp_d = model_mem[int'(a)];
            end
            last_rd = exp_d;
            run_txn(wr, a, d, be, rd, re);
            check($sformatf("rand%0d_data_out", i), 64'(rd), 64'(exp_d));
            check($sformatf("rand%0d_err", i), 64'(re), 64'(exp_e));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
